// File: rtl/cache_pkg.sv
// Shared geometry, address-field positions and controller states for the
// direct-mapped line controller.
package cache_pkg;

  localparam int OFFSET_WIDTH = 3;
  localparam int INDEX_WIDTH  = 7;
  localparam int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int BLK_W        = 32 << OFFSET_WIDTH;

  localparam int WORD_LSB  = 2;
  localparam int INDEX_LSB = WORD_LSB + OFFSET_WIDTH;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB,
    REFILL,
    INSTALL
  } state_t;

  // Byte address of the first word of a block.
  function automatic logic [31:0] block_base(input logic [TAG_WIDTH-1:0]   tag,
                                             input logic [INDEX_WIDTH-1:0] index);
    return {tag, index, {INDEX_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_ctrl_if.sv
// Word-serial burst bus between the line controller (master) and backing
// memory (slave).
interface cache_line_ctrl_if;
  import cache_pkg::*;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_burst_buf.sv
// One block of storage with a beat counter: loaded or read as a whole block,
// or filled/drained one word per beat.
module cache_burst_buf
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BLK_W-1:0] block_in,
  input  logic             word_we,
  input  logic [31:0]      word_in,
  input  logic             advance,
  output logic [BLK_W-1:0] block_out,
  output logic [31:0]      word_out,
  output logic             last
);

  logic [BLK_W-1:0]        data;
  logic [OFFSET_WIDTH-1:0] beat;

  // The beat counter wraps naturally after the final word of a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      beat <= '0;
    end else begin
      if (load) begin
        data <= block_in;
      end else if (word_we) begin
        data[{beat, 5'b0} +: 32] <= word_in;
      end
      if (advance) begin
        beat <= beat + 1'b1;
      end
    end
  end

  assign block_out = data;
  assign word_out  = data[{beat, 5'b0} +: 32];
  assign last      = &beat;

endmodule

// File: rtl/cache_line_ctrl.sv
// Miss-handling controller: checks CPU accesses against the line array,
// writes back dirty victims, refills by word bursts and installs the block.
module cache_line_ctrl
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_byte_en,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    line_enable,
  output logic                    line_cmp,
  output logic                    line_write,
  output logic                    line_valid_in,
  output logic [3:0]              line_byte_w_en,
  output logic [TAG_WIDTH-1:0]    line_tag,
  output logic [INDEX_WIDTH-1:0]  line_index,
  output logic [OFFSET_WIDTH-1:0] line_word_sel,
  output logic [31:0]             line_data_in,
  output logic [BLK_W-1:0]        line_block_in,
  input  logic                    line_hit,
  input  logic                    line_dirty,
  input  logic                    line_valid,
  input  logic [TAG_WIDTH-1:0]    line_tag_out,
  input  logic [31:0]             line_data_out,
  input  logic [BLK_W-1:0]        line_data_wb,
  cache_line_ctrl_if.master       mem
);

  state_t                  state, next_state;
  logic [TAG_WIDTH-1:0]    req_tag, victim_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_word;
  logic                    req_we;
  logic [3:0]              req_be;
  logic [31:0]             req_wdata;
  logic                    refill_active;
  logic                    hit;
  logic                    victim_load, victim_adv, victim_last, refill_beat, refill_last;
  logic [31:0]             victim_word, refill_word;
  logic [BLK_W-1:0]        victim_block, refill_block;

  assign hit = line_hit & line_valid;

  // refill_active lags REFILL entry by a cycle so mem_req drops between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_tag       <= '0;
      req_index     <= '0;
      req_word      <= '0;
      req_we        <= 1'b0;
      req_be        <= '0;
      req_wdata     <= '0;
      victim_tag    <= '0;
      refill_active <= 1'b0;
    end else begin
      state         <= next_state;
      refill_active <= (state == REFILL);
      if (state == IDLE && cpu_req) begin
        req_tag   <= cpu_addr[31:TAG_LSB];
        req_index <= cpu_addr[TAG_LSB-1:INDEX_LSB];
        req_word  <= cpu_addr[INDEX_LSB-1:WORD_LSB];
        req_we    <= cpu_we;
        req_be    <= cpu_byte_en;
        req_wdata <= cpu_wdata;
      end
      if (victim_load) begin
        victim_tag <= line_tag_out;
      end
    end
  end

  always_comb begin
    next_state     = state;
    cpu_ready      = 1'b0;
    cpu_rdata      = '0;
    line_enable    = 1'b0;
    line_cmp       = 1'b0;
    line_write     = 1'b0;
    line_valid_in  = 1'b0;
    line_byte_w_en = '0;
    line_tag       = '0;
    line_index     = '0;
    line_word_sel  = '0;
    line_data_in   = '0;
    line_block_in  = '0;
    case (state)
      IDLE: begin
        if (cpu_req) next_state = COMPARE;
      end
      COMPARE: begin
        line_enable    = 1'b1;
        line_cmp       = 1'b1;
        line_write     = req_we & line_valid;
        line_byte_w_en = req_be;
        line_tag       = req_tag;
        line_index     = req_index;
        line_word_sel  = req_word;
        line_data_in   = req_wdata;
        if (hit) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = line_data_out;
          next_state = IDLE;
        end else if (line_valid && line_dirty) begin
          next_state = WB;
        end else begin
          next_state = REFILL;
        end
      end
      WB: begin
        if (mem.mem_ack && victim_last) next_state = REFILL;
      end
      REFILL: begin
        if (refill_active && mem.mem_ack && refill_last) next_state = INSTALL;
      end
      INSTALL: begin
        line_enable    = 1'b1;
        line_write     = 1'b1;
        line_valid_in  = 1'b1;
        line_byte_w_en = 4'hF;
        line_tag       = req_tag;
        line_index     = req_index;
        line_block_in  = refill_block;
        next_state     = COMPARE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign victim_load = (state == COMPARE) && !hit;
  assign victim_adv  = (state == WB) && mem.mem_ack;
  assign refill_beat = (state == REFILL) && refill_active && mem.mem_ack;

  assign mem.mem_req   = (state == WB) || ((state == REFILL) && refill_active);
  assign mem.mem_we    = (state == WB);
  assign mem.mem_addr  = (state == WB)     ? block_base(victim_tag, req_index) :
                         (state == REFILL) ? block_base(req_tag, req_index)    : 32'h0;
  assign mem.mem_wdata = (state == WB) ? victim_word : 32'h0;

  cache_burst_buf u_victim (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (victim_load),
    .block_in  (line_data_wb),
    .word_we   (1'b0),
    .word_in   (32'h0),
    .advance   (victim_adv),
    .block_out (victim_block),
    .word_out  (victim_word),
    .last      (victim_last)
  );

  cache_burst_buf u_refill (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .block_in  ({BLK_W{1'b0}}),
    .word_we   (refill_beat),
    .word_in   (mem.mem_rdata),
    .advance   (refill_beat),
    .block_out (refill_block),
    .word_out  (refill_word),
    .last      (refill_last)
  );

  logic unused_bufs;
  assign unused_bufs = ^{victim_block, refill_word};

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: behavioural line array and burst memory around the
// DUT, checked against a flat-memory view plus a per-index residency directory.
module tb_cache_line_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byte_en;
  logic line_enable, line_cmp, line_write, line_valid_in;
  logic [3:0] line_byte_w_en;
  logic [TAG_WIDTH-1:0] line_tag, line_tag_out;
  logic [INDEX_WIDTH-1:0] line_index;
  logic [OFFSET_WIDTH-1:0] line_word_sel;
  logic [31:0] line_data_in, line_data_out;
  logic [BLK_W-1:0] line_block_in, line_data_wb;
  logic line_hit, line_dirty, line_valid;

  cache_line_ctrl_if bus ();

  cache_line_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_byte_en(cpu_byte_en),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .line_enable(line_enable), .line_cmp(line_cmp), .line_write(line_write),
    .line_valid_in(line_valid_in), .line_byte_w_en(line_byte_w_en), .line_tag(line_tag),
    .line_index(line_index), .line_word_sel(line_word_sel), .line_data_in(line_data_in),
    .line_block_in(line_block_in), .line_hit(line_hit), .line_dirty(line_dirty),
    .line_valid(line_valid), .line_tag_out(line_tag_out), .line_data_out(line_data_out),
    .line_data_wb(line_data_wb), .mem(bus)
  );

  always #5 clk = ~clk;

  // Small address space: four tags, indices 0..3, eight words each.
  function automatic logic [19:0] tagOf(input int s);
    case (s)
      0: return 20'h00000;
      1: return 20'h00001;
      2: return 20'h00041;
      default: return 20'h00007;
    endcase
  endfunction

  function automatic int slotOf(input logic [19:0] t);
    case (t)
      20'h00001: return 1;
      20'h00041: return 2;
      20'h00007: return 3;
      default:   return 0;
    endcase
  endfunction

  function automatic int wordSlot(input logic [31:0] a);
    return slotOf(a[31:12]) * 32 + int'(a[6:5]) * 8 + int'(a[4:2]);
  endfunction

  function automatic logic [31:0] initWord(input int i);
    if (i >= 48 && i < 56) return 32'hA0 + 32'(i - 48);
    return {8'hC0, 8'(i), 8'h5A, 8'(i)};
  endfunction

  // Line array: status is combinational from line_index.
  logic             arr_valid [128] = '{default: 1'b0};
  logic             arr_dirty [128] = '{default: 1'b0};
  logic [19:0]      arr_tag   [128] = '{default: 20'h0};
  logic [BLK_W-1:0] arr_blk   [128] = '{default: '0};

  assign line_valid    = arr_valid[line_index];
  assign line_dirty    = arr_dirty[line_index];
  assign line_tag_out  = arr_tag[line_index];
  assign line_hit      = (arr_tag[line_index] == line_tag);
  assign line_data_wb  = arr_blk[line_index];
  assign line_data_out = arr_blk[line_index][{line_word_sel, 5'b0} +: 32];

  always @(posedge clk) begin
    if (line_enable && line_write) begin
      if (line_cmp) begin
        if (arr_valid[line_index] && arr_tag[line_index] == line_tag) begin
          for (int b = 0; b < 4; b++)
            if (line_byte_w_en[b])
              arr_blk[line_index][{line_word_sel, 5'b0} + 8*b +: 8] <= line_data_in[8*b +: 8];
          arr_dirty[line_index] <= 1'b1;
        end
      end else begin
        arr_blk[line_index]   <= line_block_in;
        arr_tag[line_index]   <= line_tag;
        arr_valid[line_index] <= line_valid_in;
        arr_dirty[line_index] <= 1'b0;
      end
    end
  end

  // Backing memory with randomly stalled acks.
  logic [31:0] bmem [128];
  bit mem_loaded = 1'b0;
  int mem_beat;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) bmem[i] <= initWord(i);
      mem_loaded <= 1'b1;
    end else if (rst_n && bus.mem_req && bus.mem_ack && bus.mem_we) begin
      bmem[wordSlot(bus.mem_addr) + mem_beat] <= bus.mem_wdata;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_beat <= 0;
    else if (!bus.mem_req) mem_beat <= 0;
    else if (bus.mem_ack) mem_beat <= (mem_beat + 1) % 8;
  end

  always @(negedge clk) begin
    bus.mem_ack   = rst_n && bus.mem_req && ($urandom_range(0, 2) != 0);
    bus.mem_rdata = (bus.mem_req && !bus.mem_we) ? bmem[wordSlot(bus.mem_addr) + mem_beat] : 32'h0;
  end

  // Reference: what the CPU should see, and which block each index holds.
  logic [31:0] gold [128];
  bit          dir_valid [4];
  bit          dir_dirty [4];
  logic [19:0] dir_tag   [4];

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, output logic [31:0] rdata_seen);
    logic [19:0] tag;
    logic [31:0] wb_addr, rd_addr, exp_wb_addr;
    int idx, slot, cycles;
    bit exp_hit, exp_wb, saw_wb, saw_rd, prev_wb, bubble_ok, done;
    tag  = addr[31:12];
    idx  = int'(addr[6:5]);
    slot = wordSlot(addr);
    exp_hit = dir_valid[idx] && dir_tag[idx] == tag;
    exp_wb  = !exp_hit && dir_valid[idx] && dir_dirty[idx];
    exp_wb_addr = {dir_tag[idx], 7'(idx), 5'b0};
    saw_wb = 0; saw_rd = 0; prev_wb = 0; bubble_ok = 1; done = 0; cycles = 0;
    wb_addr = '0; rd_addr = '0; rdata_seen = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byte_en = be; cpu_wdata = wdata;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        checkOutput("cmp_enable", {line_enable, line_cmp}, 2'b11);
        checkOutput("cmp_write", line_write, we & dir_valid[idx]);
      end
      if (bus.mem_req && bus.mem_we) begin
        if (!saw_wb) wb_addr = bus.mem_addr;
        saw_wb = 1;
      end
      if (bus.mem_req && !bus.mem_we) begin
        if (!saw_rd) rd_addr = bus.mem_addr;
        if (prev_wb) bubble_ok = 0;
        saw_rd = 1;
      end
      prev_wb = bus.mem_req && bus.mem_we;
      if (cpu_ready) begin
        done = 1;
        rdata_seen = cpu_rdata;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    checkOutput("ready_timeout", done, 1'b1);
    checkOutput("wb_seen", saw_wb, exp_wb);
    checkOutput("refill_seen", saw_rd, !exp_hit);
    checkOutput("burst_gap", bubble_ok, 1'b1);
    if (exp_wb) checkOutput("wb_addr", wb_addr, exp_wb_addr);
    if (!exp_hit) checkOutput("refill_addr", rd_addr, {addr[31:5], 5'b0});
    if (exp_hit) checkOutput("hit_latency", cycles, 1);
    if (!we) begin
      checkOutput("rdata", rdata_seen, gold[slot]);
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) gold[slot][8*b +: 8] = wdata[8*b +: 8];
    end
    dir_dirty[idx] = exp_hit ? (dir_dirty[idx] | we) : we;
    dir_valid[idx] = 1'b1;
    dir_tag[idx]   = tag;
  endtask

  initial begin
    logic [31:0] r;
    int cycles;
    for (int i = 0; i < 128; i++) gold[i] = initWord(i);
    for (int i = 0; i < 4; i++) begin dir_valid[i] = 0; dir_dirty[i] = 0; dir_tag[i] = '0; end
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_byte_en = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {cpu_ready, bus.mem_req, line_enable, line_write}, 4'b0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h0000_1048, 1'b0, 4'h0, 32'h0, r);
    checkOutput("cold_read", r, 32'hA2);
    applyStimulus(32'h0000_1054, 1'b0, 4'h0, 32'h0, r);
    checkOutput("hit_read", r, 32'hA5);
    applyStimulus(32'h0000_1048, 1'b1, 4'b0011, 32'hDEAD_BEEF, r);
    applyStimulus(32'h0000_1048, 1'b0, 4'h0, 32'h0, r);
    checkOutput("merged_read", r, 32'h0000_BEEF);
    applyStimulus(32'h0004_1040, 1'b0, 4'h0, 32'h0, r);
    for (int w = 0; w < 8; w++) checkOutput("wb_block", bmem[48 + w], gold[48 + w]);
    checkOutput("wb_dirty_word", bmem[50], 32'h0000_BEEF);
    applyStimulus(32'h0004_1044, 1'b0, 4'h0, 32'h0, r);
    applyStimulus(32'h0000_0024, 1'b1, 4'hF, 32'h1234_5678, r);
    applyStimulus(32'h0000_0024, 1'b0, 4'h0, 32'h0, r);
    checkOutput("invalid_tag_store", r, 32'h1234_5678);

    // Abort a refill at beat 4, then replay the same load from a clean start.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7064; cpu_byte_en = '0;
    cycles = 0;
    while (!(bus.mem_req && !bus.mem_we && mem_beat == 4) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reach_refill_beat4", cycles < 200, 1'b1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    checkOutput("midburst_reset", {cpu_ready, bus.mem_req, bus.mem_we, line_enable, line_write},
                5'b0);
    checkOutput("midburst_reset_addr", {bus.mem_addr, bus.mem_wdata, cpu_rdata}, 96'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0000_7064, 1'b0, 4'h0, 32'h0, r);

    for (int n = 0; n < 70; n++) begin
      logic [31:0] a;
      a = {tagOf($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
